multicycle_ctrl: RTL and testbench

- Multi-cycle sequencing controller for the RV32I core.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Classifies the latched opcode through the existing InstTypeDecoder op_type encoding.
- Drives the register-enable, mux-select and memory-handshake strobes of the datapath.
- Counts retired instructions and traps illegal opcodes.

---
 rtl/multicycle_ctrl_pkg.sv | 36 +++
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl_inst_type_decoder.sv | 16 +
 rtl/multicycle_ctrl.sv | 138 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared encodings for the multi-cycle sequencing controller
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    localparam logic [2:0] OPT_I = 3'd0;
    localparam logic [2:0] OPT_S = 3'd2;
    localparam logic [2:0] OPT_B = 3'd3;
    localparam logic [2:0] OPT_U = 3'd4;
    localparam logic [2:0] OPT_J = 3'd5;
    localparam logic [2:0] OPT_R = 3'd6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory strobe and handshake bundle
interface multicycle_ctrl_if #(parameter int CNT_W = 32);

    logic             start;
    logic [6:0]       op_code;
    logic             branch_taken;
    logic             imem_req;
    logic             imem_ack;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             ir_we;
    logic             pc_we;
    logic             pc_sel;
    logic             rf_we;
    logic [1:0]       wb_sel;
    logic [2:0]       op_type;
    logic             retire;
    logic [CNT_W-1:0] instret;
    logic             illegal;
    logic             halted;

    modport master (
        input  start, op_code, branch_taken, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
               wb_sel, op_type, retire, instret, illegal, halted
    );

    modport slave (
        output start, op_code, branch_taken, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
               wb_sel, op_type, retire, instret, illegal, halted
    );

endinterface

// File: rtl/multicycle_ctrl_inst_type_decoder.sv
// multicycle_ctrl_inst_type_decoder: maps an RV32I opcode to its instruction-format class
module multicycle_ctrl_inst_type_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] i_op_code,
    output logic [2:0] o_op_type
);

    assign o_op_type = (i_op_code == OP_R)                              ? OPT_R :
                       (i_op_code == OP_STORE)                          ? OPT_S :
                       (i_op_code == OP_BRANCH)                         ? OPT_B :
                       (i_op_code == OP_LUI || i_op_code == OP_AUIPC)   ? OPT_U :
                       (i_op_code == OP_JAL)                            ? OPT_J :
                                                                          OPT_I;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32I datapath strobes
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W            = 32,
    parameter bit RESET_STATE_HALT = 1'b0
)(
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    localparam state_t RST_STATE = RESET_STATE_HALT ? ST_HALT : ST_FETCH;

    state_t           r_state;
    state_t           w_next;
    logic [6:0]       r_opcode;
    logic [CNT_W-1:0] r_instret;
    logic             r_illegal;
    logic [2:0]       w_op_type;
    logic             w_legal;
    logic             w_is_load;
    logic             w_is_store;
    logic             w_is_branch;
    logic             w_is_jump;
    logic             w_imem_req;
    logic             w_dmem_req;
    logic             w_dmem_we;
    logic             w_ir_we;
    logic             w_pc_we;
    logic             w_pc_sel;
    logic             w_rf_we;
    logic [1:0]       w_wb_sel;
    logic             w_retire;

    multicycle_ctrl_inst_type_decoder u_dec (
        .i_op_code (r_opcode),
        .o_op_type (w_op_type)
    );

    assign w_legal     = bus.op_code inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                                             OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, OP_SYSTEM};
    assign w_is_load   = r_opcode == OP_LOAD;
    assign w_is_store  = w_op_type == OPT_S;
    assign w_is_branch = w_op_type == OPT_B;
    assign w_is_jump   = r_opcode == OP_JAL || r_opcode == OP_JALR;

    // state register; reset lands in FETCH or HALT depending on build
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RST_STATE;
        else     r_state <= w_next;
    end

    // opcode is captured once in DECODE and held for the rest of the instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_opcode <= '0;
        else if (r_state == ST_DECODE)  r_opcode <= bus.op_code;
    end

    // retired-instruction counter and sticky illegal-opcode trap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
            if (r_state == ST_DECODE && !w_legal) r_illegal <= 1'b1;
        end
    end

    // next-state and strobe decode; only the write enables in FETCH/MEM look at acks
    always_comb begin
        w_next     = r_state;
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_ir_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_pc_sel   = 1'b0;
        w_rf_we    = 1'b0;
        w_wb_sel   = WB_ALU;
        w_retire   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                w_ir_we    = bus.imem_ack;
                w_next     = bus.imem_ack ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                w_retire = w_legal && bus.op_code == OP_SYSTEM;
                w_next   = (!w_legal || bus.op_code == OP_SYSTEM) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                w_pc_we  = w_is_branch;
                w_pc_sel = w_is_branch && bus.branch_taken;
                w_retire = w_is_branch;
                w_next   = w_is_branch                 ? ST_FETCH :
                           (w_is_load || w_is_store)   ? ST_MEM   : ST_WB;
            end
            ST_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = w_is_store;
                w_pc_we    = w_is_store && bus.dmem_ack;
                w_retire   = w_is_store && bus.dmem_ack;
                w_next     = !bus.dmem_ack ? ST_MEM   :
                             w_is_store    ? ST_FETCH : ST_WB;
            end
            ST_WB: begin
                w_rf_we  = 1'b1;
                w_pc_we  = 1'b1;
                w_retire = 1'b1;
                w_pc_sel = w_is_jump;
                w_wb_sel = w_is_load              ? WB_MEM :
                           w_is_jump              ? WB_PC4 :
                           (r_opcode == OP_LUI)   ? WB_IMM : WB_ALU;
                w_next   = ST_FETCH;
            end
            ST_HALT: w_next = bus.start ? ST_FETCH : ST_HALT;
            default: w_next = RST_STATE;
        endcase
    end

    // strobes are forced low while reset is held so an in-flight request drops at once
    assign bus.imem_req = w_imem_req & ~rst;
    assign bus.dmem_req = w_dmem_req & ~rst;
    assign bus.dmem_we  = w_dmem_we  & ~rst;
    assign bus.ir_we    = w_ir_we    & ~rst;
    assign bus.pc_we    = w_pc_we    & ~rst;
    assign bus.pc_sel   = w_pc_sel   & ~rst;
    assign bus.rf_we    = w_rf_we    & ~rst;
    assign bus.wb_sel   = rst ? WB_ALU : w_wb_sel;
    assign bus.retire   = w_retire   & ~rst;
    assign bus.op_type  = w_op_type;
    assign bus.instret  = r_instret;
    assign bus.illegal  = r_illegal;
    assign bus.halted   = r_state == ST_HALT;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction streams checked cycle-by-cycle against a latency/trace model
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CW)) bus();

    multicycle_ctrl #(.CNT_W(CW), .RESET_STATE_HALT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic          ia, da, bt, st;
        logic [6:0]    op;
        logic          e_ireq, e_dreq, e_dwe, e_irwe, e_pcwe, e_pcsel, e_rfwe, e_ret, e_halt, e_ill;
        logic [1:0]    e_wbsel;
        logic [CW-1:0] e_cnt;
        logic          chk_type;
        logic [2:0]    e_type;
    } cyc_t;

    cyc_t q[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    int   m_cnt    = 0;
    logic m_ill    = 1'b0;
    logic m_halt   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    function automatic logic [2:0] type_of(input logic [6:0] op);
        case (op)
            OP_R:            return 3'd6;
            OP_STORE:        return 3'd2;
            OP_BRANCH:       return 3'd3;
            OP_LUI, OP_AUIPC: return 3'd4;
            OP_JAL:          return 3'd5;
            default:         return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] wb_of(input logic [6:0] op);
        if (op == OP_LOAD) return 2'd1;
        if (op == OP_JAL || op == OP_JALR) return 2'd2;
        if (op == OP_LUI) return 2'd3;
        return 2'd0;
    endfunction

    function automatic cyc_t blank(input logic [6:0] op);
        cyc_t c;
        c = '0;
        c.op = op;
        c.e_cnt = CW'(m_cnt);
        c.e_ill = m_ill;
        c.e_halt = m_halt;
        c.e_type = type_of(op);
        return c;
    endfunction

    task automatic retire_model();
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    // expected trace of one instruction: iw/dw are memory wait states, bt the branch outcome
    task automatic plan_instr(input logic [6:0] op, input int iw, input int dw, input logic bt);
        cyc_t c;
        logic legal, ldst;
        legal = op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, OP_SYSTEM};
        ldst  = op == OP_LOAD || op == OP_STORE;
        for (int k = 0; k <= iw; k++) begin
            c = blank(op); c.e_ireq = 1; c.ia = (k == iw); c.e_irwe = (k == iw); c.da = 1;
            q.push_back(c);
        end
        c = blank(op); c.ia = 1; c.da = 1;
        if (!legal) begin q.push_back(c); m_ill = 1; m_halt = 1; return; end
        if (op == OP_SYSTEM) begin c.e_ret = 1; q.push_back(c); retire_model(); m_halt = 1; return; end
        q.push_back(c);
        c = blank(op); c.chk_type = 1; c.ia = 1; c.da = !ldst; c.bt = bt;
        if (op == OP_BRANCH) begin
            c.e_pcwe = 1; c.e_pcsel = bt; c.e_ret = 1; q.push_back(c); retire_model(); return;
        end
        q.push_back(c);
        if (ldst) begin
            for (int k = 0; k <= dw; k++) begin
                c = blank(op); c.chk_type = 1; c.e_dreq = 1; c.e_dwe = (op == OP_STORE); c.da = (k == dw); c.ia = 1;
                if (op == OP_STORE && k == dw) begin c.e_pcwe = 1; c.e_ret = 1; end
                q.push_back(c);
            end
            if (op == OP_STORE) begin retire_model(); return; end
        end
        c = blank(op); c.chk_type = 1; c.e_rfwe = 1; c.e_pcwe = 1; c.e_ret = 1;
        c.e_wbsel = wb_of(op); c.e_pcsel = (op == OP_JAL || op == OP_JALR);
        q.push_back(c);
        retire_model();
    endtask

    task automatic plan_halt(input int n);
        cyc_t c;
        for (int k = 0; k < n; k++) begin
            c = blank(7'd0); c.ia = 1; c.da = 1; c.st = (k == n - 1);
            q.push_back(c);
        end
        m_halt = 0;
    endtask

    // the single compare process: drive each planned cycle, sample at the falling edge
    task automatic run();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            bus.imem_ack = c.ia; bus.dmem_ack = c.da; bus.branch_taken = c.bt;
            bus.start = c.st; bus.op_code = c.op;
            @(negedge clk);
            chk("imem_req", 32'(bus.imem_req), 32'(c.e_ireq));
            chk("dmem_req", 32'(bus.dmem_req), 32'(c.e_dreq));
            chk("ir_we",    32'(bus.ir_we),    32'(c.e_irwe));
            chk("pc_we",    32'(bus.pc_we),    32'(c.e_pcwe));
            chk("rf_we",    32'(bus.rf_we),    32'(c.e_rfwe));
            chk("retire",   32'(bus.retire),   32'(c.e_ret));
            chk("halted",   32'(bus.halted),   32'(c.e_halt));
            chk("illegal",  32'(bus.illegal),  32'(c.e_ill));
            chk("instret",  32'(bus.instret),  32'(c.e_cnt));
            if (c.e_dreq)   chk("dmem_we", 32'(bus.dmem_we), 32'(c.e_dwe));
            if (c.e_pcwe)   chk("pc_sel",  32'(bus.pc_sel),  32'(c.e_pcsel));
            if (c.e_rfwe)   chk("wb_sel",  32'(bus.wb_sel),  32'(c.e_wbsel));
            if (c.chk_type) chk("op_type", 32'(bus.op_type), 32'(c.e_type));
            @(posedge clk); #1;
        end
        bus.imem_ack = 0; bus.dmem_ack = 0; bus.start = 0; bus.branch_taken = 0;
    endtask

    initial begin
        bus.start = 0; bus.op_code = 7'd0; bus.branch_taken = 0;
        bus.imem_ack = 1; bus.dmem_ack = 1;
        @(negedge clk);
        chk("rst imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst retire",   32'(bus.retire),   32'd0);
        chk("rst instret",  32'(bus.instret),  32'd0);
        chk("rst illegal",  32'(bus.illegal),  32'd0);
        chk("rst op_type",  32'(bus.op_type),  32'd0);
        chk("rst halted",   32'(bus.halted),   32'd0);
        @(posedge clk); #1 rst = 0;

        plan_instr(OP_R, 0, 0, 0);
        chk("r latency", q.size(), 32'd4);
        run();
        chk("r instret", 32'(bus.instret), 32'd1);

        plan_instr(OP_LOAD, 0, 3, 0);
        chk("load latency", q.size(), 32'd8);
        run();
        plan_instr(OP_STORE, 0, 0, 0);
        chk("store latency", q.size(), 32'd4);
        run();
        plan_instr(OP_BRANCH, 0, 0, 1);
        chk("branch latency", q.size(), 32'd3);
        plan_instr(OP_BRANCH, 0, 0, 0);
        plan_instr(OP_IMM, 2, 0, 0);
        plan_instr(OP_LUI, 0, 0, 0);
        plan_instr(OP_AUIPC, 1, 0, 0);
        plan_instr(OP_JAL, 0, 0, 0);
        plan_instr(OP_JALR, 0, 0, 0);
        plan_instr(OP_STORE, 1, 2, 0);
        plan_instr(OP_SYSTEM, 0, 0, 0);
        plan_halt(3);
        run();
        chk("system instret", 32'(bus.instret), 32'd12);

        plan_instr(7'b0000000, 0, 0, 0);
        run();
        chk("illegal flag",    32'(bus.illegal), 32'd1);
        chk("illegal halted",  32'(bus.halted),  32'd1);
        chk("illegal instret", 32'(bus.instret), 32'd12);
        plan_halt(2);
        plan_instr(OP_R, 0, 0, 0);
        run();
        chk("illegal sticky", 32'(bus.illegal), 32'd1);

        plan_instr(OP_LOAD, 0, 100, 0);
        while (q.size() > 5) void'(q.pop_back());
        run();
        chk("mid-mem dmem_req", 32'(bus.dmem_req), 32'd1);
        #1 rst = 1;
        #1;
        chk("async dmem_req drop", 32'(bus.dmem_req), 32'd0);
        chk("async imem_req low",  32'(bus.imem_req), 32'd0);
        bus.dmem_ack = 1;
        @(posedge clk); #1 rst = 0;
        m_cnt = 0; m_ill = 0; m_halt = 0;
        #1;
        chk("post-rst imem_req", 32'(bus.imem_req), 32'd1);
        chk("post-rst illegal",  32'(bus.illegal),  32'd0);
        chk("post-rst instret",  32'(bus.instret),  32'd0);
        @(posedge clk); #1;
        q.delete();
        plan_instr(OP_R, 0, 0, 0);
        for (int k = 0; k < 14; k++) plan_instr(OP_IMM, 0, 0, 0);
        run();
        chk("pre-wrap instret", 32'(bus.instret), 32'd15);
        plan_instr(OP_JAL, 0, 0, 0);
        run();
        chk("wrap instret", 32'(bus.instret), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
